launch_scheduler: RTL and testbench

- Sits between the PS/2 command interpreter (velocity, angle, fire, queue and game-reset pulses) and the missile launch engine.
- Buffers queued {velocity, angle} shots in a small FIFO.
- On a fire command, dispatches shots one at a time to the engine over a valid/ready handshake, with an enforced cooldown between launches.
- With an empty queue, fire launches the live velocity/angle once.

---
 rtl/launch_sched_pkg.sv | 13 +
 rtl/launch_fifo.sv | 48 ++++
 rtl/launch_scheduler.sv | 110 +++++++++++
 tb/tb_launch_scheduler.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/launch_sched_pkg.sv
// launch_sched_pkg: shared state encoding, default parameters and count-width helper
package launch_sched_pkg;
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_LOAD     = 2'd1;
    localparam logic [1:0] S_PRESENT  = 2'd2;
    localparam logic [1:0] S_COOLDOWN = 2'd3;
    localparam int DEPTH_DEF    = 8;
    localparam int DATA_W_DEF   = 32;
    localparam int COOLDOWN_DEF = 1000;
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/launch_fifo.sv
// launch_fifo: synchronous FIFO with push/pop/flush and registered-pointer head read
//   i_clock, i_reset   : clock, sync active-high reset
//   i_push, i_pop      : write i_data / advance head (caller guarantees legality)
//   i_flush            : empty the FIFO
//   o_head             : entry at the read pointer
//   o_count, o_full, o_empty : occupancy
module launch_fifo
    import launch_sched_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int W     = 2 * DATA_W_DEF
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_push,
    input  logic                    i_pop,
    input  logic                    i_flush,
    input  logic [W-1:0]            i_data,
    output logic [W-1:0]            o_head,
    output logic [cnt_w(DEPTH)-1:0] o_count,
    output logic                    o_full,
    output logic                    o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_count;
    always_ff @(posedge i_clock) begin
        if (i_reset | i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + AW'(1);
            if (i_pop) r_rd <= r_rd + AW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end
    always_ff @(posedge i_clock) begin
        if (i_push & ~i_reset & ~i_flush) r_mem[r_wr] <= i_data;
    end
    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
endmodule

// File: rtl/launch_scheduler.sv
// launch_scheduler: queues {velocity, angle} shots and dispatches them with a cooldown
//   i_clock, i_reset              : clock, sync active-high reset
//   i_velocity, i_angle           : live interpreted shot
//   i_queue, i_fire, i_clear      : push / start burst / flush-and-abort pulses
//   i_launch_ready                : engine accepts presented shot
//   o_launch_valid, o_launch_velocity, o_launch_angle : presented shot
//   o_busy, o_count, o_overflow   : not idle / occupancy / sticky dropped push
module launch_scheduler
    import launch_sched_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int COOLDOWN = COOLDOWN_DEF
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic [DATA_W-1:0]       i_velocity,
    input  logic [DATA_W-1:0]       i_angle,
    input  logic                    i_queue,
    input  logic                    i_fire,
    input  logic                    i_clear,
    input  logic                    i_launch_ready,
    output logic                    o_launch_valid,
    output logic [DATA_W-1:0]       o_launch_velocity,
    output logic [DATA_W-1:0]       o_launch_angle,
    output logic                    o_busy,
    output logic [cnt_w(DEPTH)-1:0] o_count,
    output logic                    o_overflow
);
    localparam int CDW = $clog2(COOLDOWN + 1);
    logic [1:0]          r_state;
    logic                r_direct;
    logic [CDW-1:0]      r_cd;
    logic                r_overflow;
    logic [DATA_W-1:0]   r_vel;
    logic [DATA_W-1:0]   r_ang;
    logic [2*DATA_W-1:0] w_head;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_push;
    // direct launches never came from the FIFO, so their handshake must not pop it
    assign w_pop  = (r_state == S_PRESENT) & i_launch_ready & ~r_direct & ~i_clear;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign w_push = i_queue & ~i_clear & (~w_full | w_pop);
    launch_fifo #(.DEPTH(DEPTH), .W(2 * DATA_W)) u_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (i_clear),
        .i_data  ({i_velocity, i_angle}),
        .o_head  (w_head),
        .o_count (o_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_direct   <= 1'b0;
            r_cd       <= '0;
            r_overflow <= 1'b0;
            r_vel      <= '0;
            r_ang      <= '0;
        end else if (i_clear) begin
            r_state    <= S_IDLE;
            r_direct   <= 1'b0;
            r_cd       <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (i_queue & w_full & ~w_pop) r_overflow <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (i_fire) begin
                        if (~w_empty | i_queue) begin
                            r_state <= S_LOAD;
                        end else begin
                            r_vel    <= i_velocity;
                            r_ang    <= i_angle;
                            r_direct <= 1'b1;
                            r_state  <= S_PRESENT;
                        end
                    end
                end
                S_LOAD: begin
                    {r_vel, r_ang} <= w_head;
                    r_direct       <= 1'b0;
                    r_state        <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (i_launch_ready) begin
                        r_cd    <= CDW'(COOLDOWN);
                        r_state <= S_COOLDOWN;
                    end
                end
                S_COOLDOWN: begin
                    r_cd <= r_cd - CDW'(1);
                    if (r_cd == CDW'(1)) r_state <= w_empty ? S_IDLE : S_LOAD;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
    assign o_launch_valid    = (r_state == S_PRESENT);
    assign o_launch_velocity = r_vel;
    assign o_launch_angle    = r_ang;
    assign o_busy            = (r_state != S_IDLE);
    assign o_overflow        = r_overflow;
endmodule

// File: tb/tb_launch_scheduler.sv
// tb_launch_scheduler: directed self-checking bench for launch_scheduler
module tb_launch_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] vel, ang;
    logic        queue, fire, clear, ready;
    logic        valid, busy, overflow;
    logic [31:0] lvel, lang;
    logic [3:0]  count;
    int          n_chk = 0;
    int          n_fail = 0;

    launch_scheduler #(.DEPTH(8), .DATA_W(32), .COOLDOWN(4)) dut (
        .i_clock           (clk),
        .i_reset           (rst),
        .i_velocity        (vel),
        .i_angle           (ang),
        .i_queue           (queue),
        .i_fire            (fire),
        .i_clear           (clear),
        .i_launch_ready    (ready),
        .o_launch_valid    (valid),
        .o_launch_velocity (lvel),
        .o_launch_angle    (lang),
        .o_busy            (busy),
        .o_count           (count),
        .o_overflow        (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] v, input logic [31:0] a);
        vel = v; ang = a; queue = 1'b1;
        tick();
        queue = 1'b0;
    endtask

    initial begin
        rst = 1'b1; vel = 0; ang = 0; queue = 0; fire = 0; clear = 0; ready = 0;
        tick(); tick();
        rst = 1'b0;
        check("rst_valid", valid, 0);
        check("rst_vel", lvel, 0);
        check("rst_ang", lang, 0);
        check("rst_busy", busy, 0);
        check("rst_count", count, 0);
        check("rst_ovf", overflow, 0);

        // direct launch
        vel = 50; ang = 30; fire = 1; ready = 1;
        tick();
        fire = 0;
        check("dir_valid", valid, 1);
        check("dir_vel", lvel, 50);
        check("dir_ang", lang, 30);
        check("dir_count", count, 0);
        tick();
        check("dir_valid_drop", valid, 0);
        check("dir_busy_cd", busy, 1);
        repeat (3) tick();
        check("dir_busy_late", busy, 1);
        check("dir_no_relaunch", valid, 0);
        tick();
        check("dir_idle", busy, 0);
        check("dir_count_end", count, 0);

        // burst of three, 6-cycle spacing
        ready = 0;
        push(10, 20); push(11, 21); push(12, 22);
        check("burst_count", count, 3);
        fire = 1; ready = 1;
        tick();
        fire = 0;
        check("burst_load_novalid", valid, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("burst_valid", valid, 1);
            check("burst_vel", lvel, 10 + i);
            check("burst_ang", lang, 20 + i);
            for (int j = 1; j <= 5; j++) begin
                tick();
                check("burst_gap", valid, 0);
            end
            if (i < 2) tick();
        end
        check("burst_idle", busy, 0);
        check("burst_count_end", count, 0);

        // backpressure
        ready = 0;
        push(40, 41);
        fire = 1;
        tick();
        fire = 0;
        tick();
        check("bp_valid0", valid, 1);
        check("bp_vel0", lvel, 40);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", valid, 1);
            check("bp_vel", lvel, 40);
            check("bp_ang", lang, 41);
            check("bp_count", count, 1);
        end
        ready = 1;
        tick();
        check("bp_valid_drop", valid, 0);
        check("bp_popped", count, 0);
        repeat (4) tick();
        check("bp_idle", busy, 0);

        // overflow and push+pop while full
        ready = 0;
        for (int i = 0; i < 9; i++) push(100 + i, 200 + i);
        check("ovf_count", count, 8);
        check("ovf_flag", overflow, 1);
        fire = 1;
        tick();
        fire = 0;
        tick();
        check("ovf_head_vel", lvel, 100);
        check("ovf_head_ang", lang, 200);
        ready = 1; vel = 300; ang = 400; queue = 1;
        tick();
        queue = 0;
        check("pp_count", count, 8);
        check("pp_ovf_sticky", overflow, 1);
        repeat (5) tick();
        for (int i = 0; i < 8; i++) begin
            check("drain_valid", valid, 1);
            check("drain_vel", lvel, (i < 7) ? 101 + i : 300);
            check("drain_ang", lang, (i < 7) ? 201 + i : 400);
            if (i < 7) repeat (6) tick();
        end
        repeat (5) tick();
        check("drain_idle", busy, 0);
        check("drain_count", count, 0);

        // simultaneous queue + fire from empty
        ready = 0; vel = 7; ang = 8; queue = 1; fire = 1;
        tick();
        queue = 0; fire = 0;
        check("sim_not_direct", valid, 0);
        check("sim_busy", busy, 1);
        check("sim_count", count, 1);
        tick();
        check("sim_valid", valid, 1);
        check("sim_vel", lvel, 7);
        check("sim_ang", lang, 8);
        ready = 1;
        tick();
        check("sim_popped", count, 0);
        repeat (4) tick();
        check("sim_idle", busy, 0);

        // clear mid-burst
        ready = 0;
        push(1, 2); push(3, 4); push(5, 6);
        fire = 1; ready = 1;
        tick();
        fire = 0;
        tick();
        check("clr_first_vel", lvel, 1);
        tick();
        ready = 0;
        repeat (5) tick();
        check("clr_pre_valid", valid, 1);
        check("clr_pre_vel", lvel, 3);
        check("clr_pre_count", count, 2);
        check("clr_pre_ovf", overflow, 1);
        clear = 1; ready = 1; queue = 1; vel = 77; ang = 88;
        tick();
        clear = 0; ready = 0; queue = 0;
        check("clr_valid", valid, 0);
        check("clr_count", count, 0);
        check("clr_busy", busy, 0);
        check("clr_ovf", overflow, 0);
        tick();
        check("clr_count_hold", count, 0);
        vel = 99; ang = 98; fire = 1;
        tick();
        fire = 0;
        check("post_dir_valid", valid, 1);
        check("post_dir_vel", lvel, 99);
        check("post_dir_ang", lang, 98);
        check("post_dir_count", count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
